// File: rtl/rcpu_mem_sequencer.sv
// rcpu_mem_sequencer: turns single-cycle CPU access requests into one (narrow)
// or two (wide) memory bus beats, stalling on memReady between beats.
// Optional feature macro: MEMSEQ_TIMEOUT_EN enables a per-beat stall counter
// that aborts a beat after TIMEOUT stalled cycles and flags err with done.
module rcpu_mem_sequencer #(
    parameter int M       = 16,
    parameter int N       = 32,
    parameter int TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req,
    input  logic           reqWE,
    input  logic           reqWide,
    input  logic [N-1:0]   reqAddr,
    input  logic [2*M-1:0] reqData,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [2*M-1:0] rdData,
    output logic [N-1:0]   memAddr,
    input  logic [M-1:0]   memRead,
    output logic [M-1:0]   memWrite,
    output logic           memRE,
    output logic           memWE,
    input  logic           memReady
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LO   = 2'd1;
    localparam logic [1:0] S_HI   = 2'd2;

    logic [1:0]     r_state;
    logic [N-1:0]   r_addr;
    logic [2*M-1:0] r_data;
    logic           r_we;
    logic           r_wide;
    logic           r_done;
    logic [2*M-1:0] r_rdData;

    logic w_strobe;
    logic w_beatDone;
    logic w_timeout;

    assign w_strobe   = (r_state != S_IDLE);
    assign w_beatDone = w_strobe && memReady;

`ifdef MEMSEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_stall;
    logic          r_err;

    // The abort fires on the edge that would make the stall count reach TIMEOUT
    assign w_timeout = w_strobe && !memReady && (r_stall == CW'(TIMEOUT - 1));

    // Per-beat stall counter, restarted whenever a beat completes or the bus is idle
    always_ff @(posedge clk) begin
        if (rst || !w_strobe || w_beatDone) begin
            r_stall <= '0;
        end else begin
            r_stall <= r_stall + CW'(1);
        end
    end

    // Error flag accompanies the done pulse of an aborted access
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_timeout;
        end
    end

    assign err = r_err;
`else
    logic w_unusedTimeout;

    assign w_timeout       = 1'b0;
    assign w_unusedTimeout = ^TIMEOUT;
    assign err             = 1'b0;
`endif

    // Sequencer FSM: latches the request in IDLE, then walks the LO and optional HI beat
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_data   <= '0;
            r_we     <= 1'b0;
            r_wide   <= 1'b0;
            r_done   <= 1'b0;
            r_rdData <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_addr  <= reqAddr;
                        r_data  <= reqData;
                        r_we    <= reqWE;
                        r_wide  <= reqWide;
                        r_state <= S_LO;
                    end
                end
                S_LO: begin
                    if (w_timeout) begin
                        r_rdData <= '1;
                        r_done   <= 1'b1;
                        r_state  <= S_IDLE;
                    end else if (memReady) begin
                        if (!r_we) begin
                            r_rdData[M-1:0] <= memRead;
                            if (!r_wide) begin
                                r_rdData[2*M-1:M] <= '0;
                            end
                        end
                        if (r_wide) begin
                            r_state <= S_HI;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_HI: begin
                    if (w_timeout) begin
                        r_rdData <= '1;
                        r_done   <= 1'b1;
                        r_state  <= S_IDLE;
                    end else if (memReady) begin
                        if (!r_we) begin
                            r_rdData[2*M-1:M] <= memRead;
                        end
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = w_strobe;
    assign done     = r_done;
    assign rdData   = r_rdData;
    assign memRE    = w_strobe && !r_we;
    assign memWE    = w_strobe && r_we;
    assign memAddr  = (r_state == S_HI) ? (r_addr + N'(1)) : r_addr;
    assign memWrite = (r_state == S_HI) ? r_data[2*M-1:M] : r_data[M-1:0];

endmodule

// File: tb/tb_rcpu_mem_sequencer.sv
// tb_rcpu_mem_sequencer: randomized scoreboard bench for rcpu_mem_sequencer
// (default build, MEMSEQ_TIMEOUT_EN undefined).
module tb_rcpu_mem_sequencer;

    localparam int M = 16;
    localparam int N = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic          reqWE;
    logic          reqWide;
    logic [31:0]   reqAddr;
    logic [31:0]   reqData;
    logic          busy;
    logic          done;
    logic          err;
    logic [31:0]   rdData;
    logic [31:0]   memAddr;
    logic [15:0]   memRead = '0;
    logic [15:0]   memWrite;
    logic          memRE;
    logic          memWE;
    logic          memReady = 1'b0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [15:0] data;
    } beat_t;

    typedef struct {
        logic [31:0] rd;
        int          issueCyc;
        int          nBeats;
    } comp_t;

    beat_t       beatQ[$];
    comp_t       compQ[$];
    logic [15:0] memModel [logic [31:0]];

    int          compared  = 0;
    int          mismatched = 0;
    int          cyc       = 0;
    int          curStalls = 0;
    int          readyMode = 0;
    bit          monEnable = 1'b1;
    logic [31:0] lastRead  = '0;

    rcpu_mem_sequencer #(.M(M), .N(N), .TIMEOUT(15)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .reqWE    (reqWE),
        .reqWide  (reqWide),
        .reqAddr  (reqAddr),
        .reqData  (reqData),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .rdData   (rdData),
        .memAddr  (memAddr),
        .memRead  (memRead),
        .memWrite (memWrite),
        .memRE    (memRE),
        .memWE    (memWE),
        .memReady (memReady)
    );

    always #5 clk = ~clk;

    // Memory contents: written words are remembered, untouched words follow a fixed pattern
    function automatic logic [15:0] memRd(input logic [31:0] a);
        if (memModel.exists(a)) return memModel[a];
        return a[15:0] ^ a[31:16] ^ 16'h5A3C;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s", name);
    endtask

    // Memory side: ready pattern and read data are driven just after each rising edge
    always @(posedge clk) begin
        cyc++;
        #1;
        case (readyMode)
            1:       memReady = 1'b1;
            2:       memReady = 1'b0;
            default: memReady = ($urandom_range(0, 3) != 0);
        endcase
        memRead = memRd(memAddr);
    end

    // Monitor: checks every completed beat and every done pulse against the scoreboard
    always @(negedge clk) begin
        if (monEnable) begin
            if ((memRE || memWE) && !memReady) curStalls++;
            if ((memRE || memWE) && memReady) begin
                if (beatQ.size() == 0) begin
                    failNow("unexpectedBeat");
                end else begin
                    beat_t b;
                    b = beatQ.pop_front();
                    checkOutput("beatAddr", 64'(memAddr), 64'(b.addr));
                    checkOutput("beatStrobes", 64'({memWE, memRE}), b.we ? 64'd2 : 64'd1);
                    if (b.we) checkOutput("beatData", 64'(memWrite), 64'(b.data));
                end
            end
            if (done) begin
                if (compQ.size() == 0) begin
                    failNow("unexpectedDone");
                end else begin
                    comp_t c;
                    c = compQ.pop_front();
                    checkOutput("rdData", 64'(rdData), 64'(c.rd));
                    checkOutput("errAtDone", 64'(err), 64'd0);
                    checkOutput("busyAtDone", 64'(busy), 64'd0);
                    checkOutput("doneLatency", 64'(cyc - c.issueCyc), 64'(1 + c.nBeats + curStalls));
                    curStalls = 0;
                end
            end
        end
    end

    // Waits (bounded) until the sequencer is idle; returns at a falling edge
    task automatic waitIdle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (busy) failNow("waitIdleTimeout");
    endtask

    // Issues one request at the current falling edge and records the expected outcome
    task automatic applyStimulus(input logic we, input logic wide, input logic [31:0] addr,
                                 input logic [31:0] data);
        beat_t       b;
        comp_t       c;
        logic [31:0] addrHi;
        addrHi  = addr + 32'd1;
        req     = 1'b1;
        reqWE   = we;
        reqWide = wide;
        reqAddr = addr;
        reqData = data;
        b.addr = addr;
        b.we   = we;
        b.data = data[15:0];
        beatQ.push_back(b);
        if (wide) begin
            b.addr = addrHi;
            b.data = data[31:16];
            beatQ.push_back(b);
        end
        if (we) begin
            memModel[addr] = data[15:0];
            if (wide) memModel[addrHi] = data[31:16];
        end else begin
            lastRead = {wide ? memRd(addrHi) : 16'h0000, memRd(addr)};
        end
        c.rd       = lastRead;
        c.issueCyc = cyc;
        c.nBeats   = wide ? 2 : 1;
        compQ.push_back(c);
        @(negedge clk);
        req = 1'b0;
        checkOutput("busyAfterReq", 64'(busy), 64'd1);
        checkOutput("loBeatAddr", 64'(memAddr), 64'(addr));
        checkOutput("loBeatStrobes", 64'({memWE, memRE}), we ? 64'd2 : 64'd1);
    endtask

    // Raises req for one cycle while busy; the sequencer must ignore it
    task automatic spuriousReq();
        if (busy) begin
            req     = 1'b1;
            reqWE   = 1'($urandom_range(0, 1));
            reqWide = 1'($urandom_range(0, 1));
            reqAddr = $urandom;
            reqData = $urandom;
            @(negedge clk);
            req = 1'b0;
        end
    endtask

    function automatic logic [31:0] randAddr();
        if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFFF - 32'($urandom_range(0, 1));
        return 32'($urandom_range(0, 15));
    endfunction

    initial begin
        rst     = 1'b1;
        req     = 1'b0;
        reqWE   = 1'b0;
        reqWide = 1'b0;
        reqAddr = '0;
        reqData = '0;
        repeat (3) @(negedge clk);
        checkOutput("resetBusy", 64'(busy), 64'd0);
        checkOutput("resetDone", 64'(done), 64'd0);
        checkOutput("resetErr", 64'(err), 64'd0);
        checkOutput("resetStrobes", 64'({memWE, memRE}), 64'd0);
        checkOutput("resetMemAddr", 64'(memAddr), 64'd0);
        checkOutput("resetMemWrite", 64'(memWrite), 64'd0);
        checkOutput("resetRdData", 64'(rdData), 64'd0);
        rst = 1'b0;

        // Zero-wait narrow read of 0xBEEF
        readyMode = 1;
        memModel[32'h100] = 16'hBEEF;
        waitIdle();
        applyStimulus(1'b0, 1'b0, 32'h100, 32'h0);

        // Wide write across the address wrap with two LO stall cycles
        readyMode = 2;
        waitIdle();
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678);
        @(negedge clk);
        readyMode = 1;

        // Wide read, ignored req while busy, then a back-to-back request
        memModel[32'h2000] = 16'hAAAA;
        memModel[32'h2001] = 16'h5555;
        waitIdle();
        applyStimulus(1'b0, 1'b1, 32'h2000, 32'h0);
        spuriousReq();
        waitIdle();
        applyStimulus(1'b0, 1'b0, 32'h100, 32'h0);

        // Reset while the HI beat of a wide read is stalled
        waitIdle();
        applyStimulus(1'b0, 1'b1, 32'h3000, 32'h0);
        readyMode = 2;
        @(negedge clk);
        rst       = 1'b1;
        monEnable = 1'b0;
        beatQ.delete();
        compQ.delete();
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midResetBusy", 64'(busy), 64'd0);
        checkOutput("midResetMemRE", 64'(memRE), 64'd0);
        checkOutput("midResetRdData", 64'(rdData), 64'd0);
        checkOutput("midResetDone", 64'(done), 64'd0);
        lastRead  = '0;
        curStalls = 0;
        monEnable = 1'b1;
        readyMode = 1;
        repeat (3) @(negedge clk);

        // No timeout in this build: a stalled beat waits indefinitely
        readyMode = 2;
        waitIdle();
        applyStimulus(1'b0, 1'b0, 32'h5, 32'h0);
        repeat (100) @(negedge clk);
        checkOutput("stallStillBusy", 64'(busy), 64'd1);
        checkOutput("stallErr", 64'(err), 64'd0);
        readyMode = 0;

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            waitIdle();
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), randAddr(), $urandom);
            if ($urandom_range(0, 2) == 0) spuriousReq();
        end

        waitIdle();
        @(negedge clk);
        checkOutput("beatQueueDrained", 64'(beatQ.size()), 64'd0);
        checkOutput("doneQueueDrained", 64'(compQ.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
